// File: rtl/key_uart_reporter.sv
// Debounced multi-key press reporter feeding a byte FIFO write port with round-robin arbitration.
// Optional macro RELEASE_REPORT_EN adds lowercase release events as extra arbiter requesters.
module key_uart_reporter #(
  parameter int         NUM_KEYS    = 4,
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         DEBOUNCE_MS = 20,
  parameter logic [7:0] CHAR_BASE   = 8'h41
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                fifo_full,
  output logic [7:0]          data_out,
  output logic                wr_en,
  output logic [NUM_KEYS-1:0] overrun
);

  localparam int CNT_MAX = CLK_FREQ / 1000 * DEBOUNCE_MS - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
`ifdef RELEASE_REPORT_EN
  localparam int REQ_N   = 2 * NUM_KEYS;
`else
  localparam int REQ_N   = NUM_KEYS;
`endif
  localparam int IDX_W   = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [NUM_KEYS-1:0] sync1_r;
  logic [NUM_KEYS-1:0] sync2_r;
  logic [NUM_KEYS-1:0] stable_r;
  logic [NUM_KEYS-1:0] stable_d_r;
  logic [CNT_W-1:0]    cnt_r [NUM_KEYS];
  logic [NUM_KEYS-1:0] press_s;
  logic [NUM_KEYS-1:0] press_pend_r;
  logic [NUM_KEYS-1:0] press_clr_s;
  logic [NUM_KEYS-1:0] press_ovr_s;
`ifdef RELEASE_REPORT_EN
  logic [NUM_KEYS-1:0] rel_s;
  logic [NUM_KEYS-1:0] rel_pend_r;
  logic [NUM_KEYS-1:0] rel_clr_s;
  logic [NUM_KEYS-1:0] rel_ovr_s;
`endif
  logic [REQ_N-1:0]    req_s;
  logic                found_s;
  logic [IDX_W-1:0]    pick_s;
  logic                grant_s;
  logic [IDX_W-1:0]    rr_r;
  logic [IDX_W-1:0]    rr_nxt_s;
  logic [7:0]          byte_s;
  logic [7:0]          data_nxt_s;
  logic                wr_en_nxt_s;
  state_t              state_r;
  state_t              state_nxt_s;

  // Two-flop synchroniser; reset to released so no false press appears at startup
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_r <= {NUM_KEYS{1'b1}};
      sync2_r <= {NUM_KEYS{1'b1}};
    end else begin
      sync1_r <= key_in;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: stable state flips only after CNT_MAX+1 consecutive differing samples
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      stable_r   <= {NUM_KEYS{1'b1}};
      stable_d_r <= {NUM_KEYS{1'b1}};
    end else begin
      stable_d_r <= stable_r;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          stable_r[i] <= sync2_r[i];
          cnt_r[i]    <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press_s = stable_d_r & ~stable_r;
`ifdef RELEASE_REPORT_EN
  assign rel_s   = ~stable_d_r & stable_r;
  assign req_s   = {rel_pend_r, press_pend_r};
`else
  assign req_s   = press_pend_r;
`endif

  // Grant-clear vectors and lost-event detection; a same-cycle set beats the clear
  always_comb begin
    press_clr_s = {NUM_KEYS{1'b0}};
`ifdef RELEASE_REPORT_EN
    rel_clr_s   = {NUM_KEYS{1'b0}};
`endif
    for (int i = 0; i < NUM_KEYS; i++) begin
      press_clr_s[i] = grant_s && (int'(pick_s) == i);
`ifdef RELEASE_REPORT_EN
      rel_clr_s[i]   = grant_s && (int'(pick_s) == (NUM_KEYS + i));
`endif
    end
    press_ovr_s = press_s & press_pend_r & ~press_clr_s;
`ifdef RELEASE_REPORT_EN
    rel_ovr_s   = rel_s & rel_pend_r & ~rel_clr_s;
`endif
  end

  // Pending events and sticky overrun flags
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      press_pend_r <= {NUM_KEYS{1'b0}};
      overrun      <= {NUM_KEYS{1'b0}};
`ifdef RELEASE_REPORT_EN
      rel_pend_r   <= {NUM_KEYS{1'b0}};
`endif
    end else begin
      press_pend_r <= press_s | (press_pend_r & ~press_clr_s);
`ifdef RELEASE_REPORT_EN
      rel_pend_r   <= rel_s | (rel_pend_r & ~rel_clr_s);
      overrun      <= overrun | press_ovr_s | rel_ovr_s;
`else
      overrun      <= overrun | press_ovr_s;
`endif
    end
  end

  // Round-robin search starting at rr_r and wrapping past the top requester
  always_comb begin
    int               tmp;
    logic [IDX_W-1:0] idx;
    found_s = 1'b0;
    pick_s  = IDX_ZERO;
    tmp     = 0;
    idx     = IDX_ZERO;
    for (int k = 0; k < REQ_N; k++) begin
      tmp = int'(rr_r) + k;
      if (tmp >= REQ_N) begin
        tmp = tmp - REQ_N;
      end else begin
        tmp = tmp;
      end
      idx = IDX_W'(tmp);
      if (!found_s && req_s[idx]) begin
        found_s = 1'b1;
        pick_s  = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  // ASCII code for the winning requester
  always_comb begin
`ifdef RELEASE_REPORT_EN
    if (int'(pick_s) >= NUM_KEYS) begin
      byte_s = CHAR_BASE + 8'h20 + 8'(int'(pick_s) - NUM_KEYS);
    end else begin
      byte_s = CHAR_BASE + 8'(pick_s);
    end
`else
    byte_s = CHAR_BASE + 8'(pick_s);
`endif
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    case (state_r)
      IDLE:    state_nxt_s = grant_s ? SEND : IDLE;
      SEND:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: fifo_full only matters when a grant is being considered
  always_comb begin
    case (state_r)
      IDLE:    grant_s = found_s && !fifo_full;
      SEND:    grant_s = 1'b0;
      default: grant_s = 1'b0;
    endcase
    wr_en_nxt_s = grant_s;
    if (grant_s) begin
      data_nxt_s = byte_s;
      rr_nxt_s   = (int'(pick_s) == (REQ_N - 1)) ? IDX_ZERO : (pick_s + IDX_ONE);
    end else begin
      data_nxt_s = data_out;
      rr_nxt_s   = rr_r;
    end
  end

  // Registered outputs; async reset drops wr_en immediately, discarding any in-flight byte
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_out <= 8'h00;
      wr_en    <= 1'b0;
      rr_r     <= IDX_ZERO;
    end else begin
      data_out <= data_nxt_s;
      wr_en    <= wr_en_nxt_s;
      rr_r     <= rr_nxt_s;
    end
  end

endmodule

// File: tb/tb_key_uart_reporter.sv
// Directed scoreboard bench for key_uart_reporter (fast debounce: CNT_MAX=49).
// Release bytes are expected only when RELEASE_REPORT_EN is defined.
module tb_key_uart_reporter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic       fifo_full = 1'b0;
  logic [7:0] data_out;
  logic       wr_en;
  logic [3:0] overrun;

  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  logic       prev_wr = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] mon_exp;
  logic [7:0] exp_q[$];

  key_uart_reporter #(
    .NUM_KEYS   (4),
    .CLK_FREQ   (50_000),
    .DEBOUNCE_MS(1),
    .CHAR_BASE  (8'h41)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .key_in   (key_in),
    .fifo_full(fifo_full),
    .data_out (data_out),
    .wr_en    (wr_en),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Write monitor: pops the scoreboard on every strobe and checks strobe spacing
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 1'b0;
    end else begin
      if (wr_en) begin
        wr_cnt++;
        checks++;
        assert (prev_wr === 1'b0) else begin
          errors++;
          $error("FAIL strobe_gap: observed back-to-back wr_en, expected idle cycle");
        end
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed byte %0h, expected no write", data_out);
        end
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          last_byte = mon_exp;
          checks++;
          assert (data_out === mon_exp) else begin
            errors++;
            $error("FAIL write_byte: observed %0h expected %0h", data_out, mon_exp);
          end
        end
      end
      prev_wr = wr_en;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s: observed %0d bytes outstanding, expected 0", tag, exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    key_in = 4'hF;
    fifo_full = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int w0;

    // Reset held while keys toggle
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      key_in = 4'($urandom);
      @(negedge clk);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_data", {24'd0, data_out}, 32'd0);
      chk("rst_overrun", {28'd0, overrun}, 32'd0);
    end
    key_in = 4'hF;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Single press of key 2: latency and byte
    key_in[2] = 1'b0;
    exp_q.push_back(8'h43);
    lat = 0;
    while (!wr_en && lat < 200) begin
      tick(1);
      lat++;
    end
    chk("key2_latency", lat, 32'd54);
    tick(6);
    key_in[2] = 1'b1;
`ifdef RELEASE_REPORT_EN
    exp_q.push_back(8'h63);
`endif
    drain("key2_drain", 150);
    tick(5);
    chk("data_hold", {24'd0, data_out}, {24'd0, last_byte});
    chk("key2_writes",
`ifdef RELEASE_REPORT_EN
        wr_cnt, 32'd2);
`else
        wr_cnt, 32'd1);
`endif

    // Glitch on key 1 shorter than the debounce window
    w0 = wr_cnt;
    key_in[1] = 1'b0;
    tick(30);
    key_in[1] = 1'b1;
    tick(100);
    chk("glitch_no_write", wr_cnt, w0);
    chk("glitch_overrun", {28'd0, overrun}, 32'd0);

    // Simultaneous presses of keys 0,1,3 from a fresh round-robin pointer
    do_reset();
    w0 = wr_cnt;
    key_in = 4'b0100;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h44);
    tick(65);
    drain("multi_press", 50);
    key_in = 4'hF;
`ifdef RELEASE_REPORT_EN
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    exp_q.push_back(8'h64);
`endif
    tick(65);
    drain("multi_release", 50);
`ifdef RELEASE_REPORT_EN
    chk("multi_writes", wr_cnt - w0, 32'd6);
`else
    chk("multi_writes", wr_cnt - w0, 32'd3);
`endif
    chk("multi_overrun", {28'd0, overrun}, 32'd0);

    // Backpressure: press, release, press again while fifo_full holds
    do_reset();
    w0 = wr_cnt;
    fifo_full = 1'b1;
    key_in[0] = 1'b0;
    tick(60);
    key_in[0] = 1'b1;
    tick(60);
    key_in[0] = 1'b0;
    tick(60);
    chk("full_no_write", wr_cnt, w0);
    chk("full_overrun", {28'd0, overrun}, 32'd1);
    exp_q.push_back(8'h41);
`ifdef RELEASE_REPORT_EN
    exp_q.push_back(8'h61);
`endif
    fifo_full = 1'b0;
    drain("full_drain", 60);
    chk("full_overrun_sticky", {28'd0, overrun}, 32'd1);
    key_in[0] = 1'b1;
`ifdef RELEASE_REPORT_EN
    exp_q.push_back(8'h61);
`endif
    tick(70);
    drain("full_release", 50);
    chk("full_overrun_final", {28'd0, overrun}, 32'd1);

`ifdef RELEASE_REPORT_EN
    // Key 3 press then release gives upper then lower case
    key_in[3] = 1'b0;
    exp_q.push_back(8'h44);
    tick(60);
    key_in[3] = 1'b1;
    exp_q.push_back(8'h64);
    drain("key3_press_release", 150);
`endif

    // Reset asserted while a byte is being strobed
    do_reset();
    key_in[2] = 1'b0;
    lat = 0;
    while (!wr_en && lat < 200) begin
      tick(1);
      lat++;
    end
    chk("midsend_seen", {31'd0, wr_en}, 32'd1);
    w0 = wr_cnt;
    #2;
    rst_n = 1'b0;
    key_in = 4'hF;
    #1;
    chk("midsend_drop", {31'd0, wr_en}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(150);
    chk("midsend_no_write", wr_cnt, w0);
    chk("midsend_data", {24'd0, data_out}, 32'd0);
    chk("midsend_overrun", {28'd0, overrun}, 32'd0);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
